// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// | fetch_queue_if : push/pop/flush bundle between PC stage, queue, ID stage |
// | Revision 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             flush;
  logic             push_valid;
  logic [31:0]      push_pc;
  logic [31:0]      push_inst;
  logic [7:0]       push_exc;
  logic             full;
  logic             pop_ready;
  logic             pop_valid;
  logic [31:0]      pop_pc;
  logic [31:0]      pop_inst;
  logic [7:0]       pop_exc;
  logic [PTR_W:0]   count;

  modport master (
    output flush, push_valid, push_pc, push_inst, push_exc, pop_ready,
    input  full, pop_valid, pop_pc, pop_inst, pop_exc, count
  );

  modport slave (
    input  flush, push_valid, push_pc, push_inst, push_exc, pop_ready,
    output full, pop_valid, pop_pc, pop_inst, pop_exc, count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// | fetch_queue : instruction fetch FIFO between PC stage and ID stage       |
// | Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN      |
// | Revision 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  fetch_queue_if.slave     bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  exc;
  } entry_t;

  localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [PTR_W:0]   r_count;

  entry_t w_push_entry;
  entry_t w_head;
  logic   w_empty;
  logic   w_full;
  logic   w_bypass;
  logic   w_pop_valid;
  logic   w_push_fire;
  logic   w_pop_fire;
  logic   w_bypass_take;
  logic   w_wr;
  logic   w_rd;

  // A faulting fetch carries no usable instruction, so it is stored as a NOP.
  always_comb begin
    w_push_entry.pc   = bus.push_pc;
    w_push_entry.inst = (bus.push_exc != 8'h00) ? 32'h0000_0000 : bus.push_inst;
    w_push_entry.exc  = bus.push_exc;
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && bus.push_valid && !bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop_valid   = !w_empty || w_bypass;
  assign w_push_fire   = bus.push_valid && !w_full && !bus.flush;
  assign w_pop_fire    = w_pop_valid && bus.pop_ready && !bus.flush;
  // A bypassed entry consumed in the same cycle never touches the array.
  assign w_bypass_take = w_bypass && bus.pop_ready;
  assign w_wr          = w_push_fire && !w_bypass_take;
  assign w_rd          = w_pop_fire && !w_bypass_take;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + c_ptr_one;
      end
      if (w_rd) begin
        r_rp <= r_rp + c_ptr_one;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  always_comb begin
    w_head = '0;
    if (w_bypass) begin
      w_head = w_push_entry;
    end else if (!w_empty) begin
      w_head = r_mem[r_rp];
    end
  end

  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.pop_valid = w_pop_valid;
  assign bus.pop_pc    = w_head.pc;
  assign bus.pop_inst  = w_head.inst;
  assign bus.pop_exc   = w_head.exc;

endmodule

`default_nettype wire
